// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: decides per cycle whether IF/ID/EX/MEM advance, hold or take a bubble,
// covering RAW hazards, taken-branch flushes and data-memory wait states.
module pipeline_hazard_ctrl #(
  parameter int unsigned BR_FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             id_valid,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_id_ex,
  output logic             freeze_ex_mem,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned FCNT_W     = 4;
  localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(BR_FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              hazard;
  logic              memstall;

  assign memstall = mem_req & ~mem_ready;
  assign state    = state_q;

  // With forwarding only a load in EXE can't be bypassed into ID.
  always_comb begin
    hazard = 1'b0;
    if (id_valid) begin
      if (fwd_en) begin
        hazard = exe_mem_r_en & ((exe_dest == src1) | (two_src & (exe_dest == src2)));
      end else begin
        hazard = (exe_wb_en & ((exe_dest == src1) | (two_src & (exe_dest == src2)))) |
                 (mem_wb_en & ((mem_dest == src1) | (two_src & (mem_dest == src2))));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state and control outputs; everything stays low while reset is held.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_ex  = 1'b0;
    freeze_id_ex  = 1'b0;
    freeze_ex_mem = 1'b0;
    if (rst) begin
      if (memstall) begin
        freeze_pc     = 1'b1;
        freeze_if_id  = 1'b1;
        freeze_id_ex  = 1'b1;
        freeze_ex_mem = 1'b1;
        if (state_q != FLUSH) state_d = MEM_WAIT;
      end else if (state_q == FLUSH) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        fcnt_d       = fcnt_q - FCNT_W'(1);
        if (fcnt_q <= FCNT_W'(1)) begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      end else if (branch_taken) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        if (FLUSH_INIT != '0) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_INIT;
        end else begin
          state_d = RUN;
        end
      end else begin
        state_d = RUN;
        if (hazard) begin
          freeze_pc    = 1'b1;
          freeze_if_id = 1'b1;
          bubble_id_ex = 1'b1;
        end
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (freeze_pc && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two builds (1-cycle flush / 16-bit count and
// 3-cycle flush / 4-bit count) share stimulus and are compared against a rule-level model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned BR_A = 1;
  localparam int unsigned CW_A = 16;
  localparam int unsigned BR_B = 3;
  localparam int unsigned CW_B = 4;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic two_src, id_valid, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en;
  logic branch_taken, mem_req, mem_ready;

  // ctrl = {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_id_ex, freeze_ex_mem}
  wire [5:0]      ctrl_a, ctrl_b;
  wire [1:0]      state_a, state_b;
  wire [CW_A-1:0] cnt_a;
  wire [CW_B-1:0] cnt_b;

  int tests_run    = 0;
  int tests_failed = 0;

  int flush_left[2];
  bit waiting[2];
  int stalls[2];
  int br_len[2]  = '{BR_A, BR_B};
  int cnt_max[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.BR_FLUSH_CYCLES(BR_A), .CNT_W(CW_A)) u_a (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(ctrl_a[5]), .freeze_if_id(ctrl_a[4]), .flush_if_id(ctrl_a[3]),
    .bubble_id_ex(ctrl_a[2]), .freeze_id_ex(ctrl_a[1]), .freeze_ex_mem(ctrl_a[0]),
    .state(state_a), .stall_count(cnt_a)
  );

  pipeline_hazard_ctrl #(.BR_FLUSH_CYCLES(BR_B), .CNT_W(CW_B)) u_b (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(ctrl_b[5]), .freeze_if_id(ctrl_b[4]), .flush_if_id(ctrl_b[3]),
    .bubble_id_ex(ctrl_b[2]), .freeze_id_ex(ctrl_b[1]), .freeze_ex_mem(ctrl_b[0]),
    .state(state_b), .stall_count(cnt_b)
  );

  // ---------------- reference model ----------------
  function automatic bit hazard_ref();
    bit reads[16];
    reads = '{default: 1'b0};
    if (!id_valid) return 1'b0;
    reads[src1] = 1'b1;
    if (two_src) reads[src2] = 1'b1;
    if (fwd_en) return exe_mem_r_en && reads[exe_dest];
    return (exe_wb_en && reads[exe_dest]) || (mem_wb_en && reads[mem_dest]);
  endfunction

  function automatic logic [5:0] exp_ctrl(int i);
    if (!rst) return 6'b000000;
    if (mem_req && !mem_ready) return 6'b110011;
    if (flush_left[i] > 0 || branch_taken) return 6'b001100;
    if (hazard_ref()) return 6'b110100;
    return 6'b000000;
  endfunction

  function automatic logic [1:0] exp_state(int i);
    if (flush_left[i] > 0) return 2'd1;
    if (waiting[i]) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [5:0] obs_ctrl(int i);
    return (i == 0) ? ctrl_a : ctrl_b;
  endfunction

  function automatic logic [1:0] obs_state(int i);
    return (i == 0) ? state_a : state_b;
  endfunction

  function automatic int obs_cnt(int i);
    return (i == 0) ? int'(cnt_a) : int'(cnt_b);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      flush_left[i] = 0;
      waiting[i]    = 1'b0;
      stalls[i]     = 0;
    end
  endtask

  task automatic model_edge();
    bit ms;
    if (!rst) begin
      model_reset();
      return;
    end
    ms = mem_req && !mem_ready;
    for (int i = 0; i < 2; i++) begin
      if (exp_ctrl(i)[5] && stalls[i] < cnt_max[i]) stalls[i]++;
      if (ms) begin
        if (flush_left[i] == 0) waiting[i] = 1'b1;
      end else begin
        waiting[i] = 1'b0;
        if (flush_left[i] > 0) flush_left[i]--;
        else if (branch_taken) flush_left[i] = br_len[i] - 1;
      end
    end
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    src1 = 4'd0; src2 = 4'd0; two_src = 1'b0; id_valid = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; fwd_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    set_idle();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; id_valid = 1'b1;
    mem_req = 1'b1; branch_taken = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if ({ctrl_a, ctrl_b, state_a, state_b, cnt_a, cnt_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset: ctrl_a=%b ctrl_b=%b st=%0d/%0d cnt=%0d/%0d expected all zero",
               ctrl_a, ctrl_b, state_a, state_b, cnt_a, cnt_b);
    end
    apply_reset();
  endtask

  task automatic test_raw_nofwd();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      set_idle();
      id_valid = 1'b1; exe_wb_en = 1'b1;
      if (c == 0) begin src1 = 4'd3; exe_dest = 4'd3; end
      else begin src1 = 4'd1; src2 = 4'd3; two_src = 1'b0; exe_dest = 4'd5; mem_dest = 4'd3; end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs_ctrl(i) !== exp_ctrl(i) || obs_state(i) !== exp_state(i) || obs_cnt(i) != stalls[i]) begin
          tests_failed++;
          $display("FAIL raw_nofwd inst%0d cyc%0d: ctrl=%b st=%0d cnt=%0d expected ctrl=%b st=%0d cnt=%0d",
                   i, c, obs_ctrl(i), obs_state(i), obs_cnt(i), exp_ctrl(i), exp_state(i), stalls[i]);
        end
      end
      tick();
    end
    tests_run++;
    if (cnt_a !== 16'd1) begin
      tests_failed++;
      $display("FAIL raw_nofwd_count: stall_count=%0d expected 1", cnt_a);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      fwd_en = 1'b1; id_valid = 1'b1; src1 = 4'd4;
      if (c < 2) begin exe_dest = 4'd4; exe_wb_en = 1'b1; exe_mem_r_en = (c == 1); end
      else begin mem_dest = 4'd4; mem_wb_en = 1'b1; end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs_ctrl(i) !== exp_ctrl(i) || obs_state(i) !== exp_state(i) || obs_cnt(i) != stalls[i]) begin
          tests_failed++;
          $display("FAIL load_use inst%0d cyc%0d: ctrl=%b st=%0d cnt=%0d expected ctrl=%b st=%0d cnt=%0d",
                   i, c, obs_ctrl(i), obs_state(i), obs_cnt(i), exp_ctrl(i), exp_state(i), stalls[i]);
        end
      end
      tick();
    end
    tests_run++;
    if (cnt_a !== 16'd1) begin
      tests_failed++;
      $display("FAIL load_use_count: stall_count=%0d expected 1", cnt_a);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      id_valid = 1'b1; src1 = 4'd7; exe_dest = 4'd7; exe_wb_en = (c == 0);
      branch_taken = (c == 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs_ctrl(i) !== exp_ctrl(i) || obs_state(i) !== exp_state(i) || obs_cnt(i) != stalls[i]) begin
          tests_failed++;
          $display("FAIL branch inst%0d cyc%0d: ctrl=%b st=%0d cnt=%0d expected ctrl=%b st=%0d cnt=%0d",
                   i, c, obs_ctrl(i), obs_state(i), obs_cnt(i), exp_ctrl(i), exp_state(i), stalls[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      set_idle();
      mem_req = (c < 4); mem_ready = (c == 3);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs_ctrl(i) !== exp_ctrl(i) || obs_state(i) !== exp_state(i) || obs_cnt(i) != stalls[i]) begin
          tests_failed++;
          $display("FAIL mem_wait inst%0d cyc%0d: ctrl=%b st=%0d cnt=%0d expected ctrl=%b st=%0d cnt=%0d",
                   i, c, obs_ctrl(i), obs_state(i), obs_cnt(i), exp_ctrl(i), exp_state(i), stalls[i]);
        end
      end
      tick();
    end
    tests_run++;
    if (cnt_a !== 16'd3 || state_a !== 2'd0) begin
      tests_failed++;
      $display("FAIL mem_wait_count: stall_count=%0d state=%0d expected 3 and 0", cnt_a, state_a);
    end
  endtask

  task automatic test_flush_memstall();
    int flush_seen;
    flush_seen = 0;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      set_idle();
      branch_taken = (c == 0);
      mem_req = (c >= 1 && c <= 3); mem_ready = (c == 3);
      @(negedge clk);
      if (ctrl_b[3]) flush_seen++;
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs_ctrl(i) !== exp_ctrl(i) || obs_state(i) !== exp_state(i) || obs_cnt(i) != stalls[i]) begin
          tests_failed++;
          $display("FAIL flush_memstall inst%0d cyc%0d: ctrl=%b st=%0d cnt=%0d expected ctrl=%b st=%0d cnt=%0d",
                   i, c, obs_ctrl(i), obs_state(i), obs_cnt(i), exp_ctrl(i), exp_state(i), stalls[i]);
        end
      end
      tick();
    end
    tests_run++;
    if (flush_seen != 3) begin
      tests_failed++;
      $display("FAIL flush_total: flush cycles=%0d expected 3", flush_seen);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    set_idle();
    mem_req = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    set_idle();
    @(negedge clk);
    tests_run++;
    if (cnt_b !== 4'd15 || cnt_a !== 16'd20) begin
      tests_failed++;
      $display("FAIL saturation: cnt_b=%0d cnt_a=%0d expected 15 and 20", cnt_b, cnt_a);
    end
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_idle();
    mem_req = 1'b1;
    tick();
    tick();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({ctrl_a, ctrl_b, state_a, state_b, cnt_a, cnt_b} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: ctrl_a=%b ctrl_b=%b st=%0d/%0d cnt=%0d/%0d expected all zero",
               ctrl_a, ctrl_b, state_a, state_b, cnt_a, cnt_b);
    end
    model_reset();
    tick();
    set_idle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs_ctrl(i) !== exp_ctrl(i) || obs_state(i) !== exp_state(i) || obs_cnt(i) != stalls[i]) begin
        tests_failed++;
        $display("FAIL async_release inst%0d: ctrl=%b st=%0d cnt=%0d expected ctrl=%b st=%0d cnt=%0d",
                 i, obs_ctrl(i), obs_state(i), obs_cnt(i), exp_ctrl(i), exp_state(i), stalls[i]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      src1 = 4'($urandom_range(0, 3)); src2 = 4'($urandom_range(0, 3));
      two_src = 1'($urandom); id_valid = ($urandom_range(0, 7) != 0);
      exe_dest = 4'($urandom_range(0, 3)); exe_wb_en = 1'($urandom);
      exe_mem_r_en = ($urandom_range(0, 2) == 0);
      mem_dest = 4'($urandom_range(0, 3)); mem_wb_en = 1'($urandom);
      fwd_en = 1'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_req = ($urandom_range(0, 3) == 0); mem_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs_ctrl(i) !== exp_ctrl(i) || obs_state(i) !== exp_state(i) || obs_cnt(i) != stalls[i]) begin
          tests_failed++;
          $display("FAIL random inst%0d cyc%0d: ctrl=%b st=%0d cnt=%0d expected ctrl=%b st=%0d cnt=%0d",
                   i, c, obs_ctrl(i), obs_state(i), obs_cnt(i), exp_ctrl(i), exp_state(i), stalls[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_raw_nofwd();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_flush_memstall();
    test_saturation();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Pipeline sequencer for the ARM core; sits beside the ID-stage and ID/EX register.
- Decides each cycle whether IF/ID/EX/MEM advance, hold, or receive a bubble.
- Handles three events:
  - RAW hazard detection, with or without forwarding (load-use stalls only when forwarding is on).
  - Taken-branch flush sequencing.
  - A ready/req handshake with the data-memory controller, which freezes the whole pipe.
- Drives the freeze/flush inputs of the pipeline registers and keeps a stall-cycle statistic.

Parameters:
BR_FLUSH_CYCLES, 1, cycles of IF/ID flush + ID/EX bubble per taken branch (1..15)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
src1  in  4  Rn of instruction in ID
src2  in  4  second source (Rm or Rd for STR) of instruction in ID
two_src  in  1  ID instruction reads src2
id_valid  in  1  ID holds a real instruction (0 = bubble, no hazard)
exe_dest  in  4  Dest of instruction in EXE
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
mem_dest  in  4  Dest of instruction in MEM
mem_wb_en  in  1  MEM instruction writes back
fwd_en  in  1  forwarding unit enabled
branch_taken  in  1  B asserted by EXE, condition passed
mem_req  in  1  MEM stage performs a memory access this cycle
mem_ready  in  1  memory controller completes access this cycle
freeze_pc  out  1  hold PC
freeze_if_id  out  1  hold IF/ID register
flush_if_id  out  1  clear IF/ID register
bubble_id_ex  out  1  load zeros into ID/EX control fields (flush input)
freeze_id_ex  out  1  hold ID/EX register
freeze_ex_mem  out  1  hold EX/MEM register and block MEM/WB update
state  out  2  0=RUN, 1=FLUSH, 2=MEM_WAIT
stall_count  out  CNT_W  saturating count of cycles with freeze_pc=1

Behaviour:
- Registers: FSM state, flush down-counter (4 bit), stall_count. Control outputs are combinational from the registers and inputs, so they act in the same cycle.
- rst low (async): state=RUN, flush counter=0, stall_count=0. While rst is low, all control outputs are 0.
- hazard (combinational; always 0 if id_valid=0):
  - fwd_en=0: exe_wb_en & (exe_dest==src1 | two_src & exe_dest==src2), OR mem_wb_en & (mem_dest==src1 | two_src & mem_dest==src2).
  - fwd_en=1: exe_mem_r_en & (exe_dest==src1 | two_src & exe_dest==src2).
- memstall = mem_req & ~mem_ready.
- Priority every cycle: memstall > branch/flush > hazard.
- RUN:
  - memstall: assert freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem; next state MEM_WAIT.
  - else branch_taken: assert flush_if_id and bubble_id_ex.
    - BR_FLUSH_CYCLES=1: stay RUN.
    - Otherwise: next state FLUSH, counter=BR_FLUSH_CYCLES-1.
    - hazard is ignored, because the ID instruction is being squashed.
  - else hazard: assert freeze_pc, freeze_if_id, bubble_id_ex; stay RUN.
  - else: all control outputs 0.
- MEM_WAIT:
  - While memstall: all four freezes asserted.
  - When mem_ready=1: no freeze that cycle; next state RUN. Branch and hazard are evaluated with RUN rules in the same cycle.
  - If mem_req drops without mem_ready, also return to RUN (controller abort).
- FLUSH:
  - Assert flush_if_id and bubble_id_ex; decrement the counter; go to RUN when the counter reaches 0 (transition happens on the edge where counter==1).
  - memstall in FLUSH: freeze all four registers, suppress flush/bubble, hold the counter, stay in FLUSH.
  - A new branch_taken in FLUSH is impossible (EXE holds a bubble) and is ignored.
- stall_count: +1 on every cycle with freeze_pc=1; saturates at all-ones and never wraps.
- Output combinations:
  - freeze_id_ex and bubble_id_ex are never asserted together.
  - flush_if_id and freeze_if_id are never asserted together.
- Reset mid-MEM_WAIT or mid-FLUSH: immediate return to RUN; no pending flush is retained.

Test Plan:
1. fwd_en=0, id_valid=1, src1=3, exe_wb_en=1, exe_dest=3 -> freeze_pc=freeze_if_id=bubble_id_ex=1, state stays 0, stall_count 0->1. Repeat with two_src=0, src2=3, exe_dest=5 -> no hazard.
2. fwd_en=1, exe_wb_en=1, exe_mem_r_en=0, exe_dest=src1=4 -> no stall. Set exe_mem_r_en=1 -> exactly one stall cycle, then clears once EXE holds the bubble.
3. BR_FLUSH_CYCLES=2, branch_taken pulse for 1 cycle together with a hazard -> flush_if_id=bubble_id_ex=1 for 2 cycles, state 0->1->0, freeze_pc=0 throughout.
4. mem_req=1, mem_ready=0 for 3 cycles, then 1 -> all four freezes=1 for 3 cycles, state=2; the ready cycle has freezes=0 and state returns to 0; stall_count=3.
5. memstall during FLUSH with BR_FLUSH_CYCLES=3 -> flush suppressed while stalled, counter held; after ready, remaining flush cycles complete (3 total).
6. Drive rst low asynchronously mid-MEM_WAIT -> outputs 0 and state=0 immediately, stall_count=0. Also preload a CNT_W=4 build to 15 stalled cycles -> stall_count holds at 15.
